// File: rtl/grade_display_sequencer_if.sv
// Switch/display bundle between the grade sequencer and its environment.
// The master side drives switches and observes the classifier-facing outputs.
interface grade_display_sequencer_if #(
  parameter int unsigned NSLOTS = 8
);
  localparam int unsigned SW = $clog2(NSLOTS);
  localparam int unsigned CW = $clog2(NSLOTS + 1);

  logic [3:0]    grade_in;
  logic          load;
  logic          clear;
  logic          run;
  logic [3:0]    nota_out;
  logic          show_status;
  logic [SW-1:0] slot_out;
  logic [CW-1:0] count_out;
  logic          full;
  logic          err;

  modport master (
    output grade_in, load, clear, run,
    input  nota_out, show_status, slot_out, count_out, full, err
  );

  modport slave (
    input  grade_in, load, clear, run,
    output nota_out, show_status, slot_out, count_out, full, err
  );
endinterface

// File: rtl/grade_display_sequencer.sv
// Stores up to NSLOTS grades and, while run is high, rotates the classifier
// through each entry: numeric grade for DWELL cycles, then status for DWELL.
module grade_display_sequencer #(
  parameter int unsigned NSLOTS = 8,
  parameter int unsigned DWELL  = 4
) (
  input  logic                       clk_2,
  input  logic                       reset,
  grade_display_sequencer_if.slave   bus
);
  localparam int unsigned SW = $clog2(NSLOTS);
  localparam int unsigned CW = $clog2(NSLOTS + 1);
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHOW_GRADE,
    SHOW_STATUS
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_mem [NSLOTS];
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_slot;
  logic [SW-1:0] w_slot_next;
  logic [DW-1:0] r_dwell;
  logic [DW-1:0] w_dwell_next;
  logic          r_err;
  logic          r_load_prev;
  logic [3:0]    r_nota;
  logic [3:0]    w_nota_next;
  logic          r_show;
  logic          w_show_next;
  logic          w_load_rise;
  logic          w_full;
  logic          w_grade_ok;
  logic          w_dwell_last;
  logic          w_store;

  assign w_load_rise  = bus.load & ~r_load_prev;
  assign w_full       = (r_count == CW'(NSLOTS));
  assign w_grade_ok   = (bus.grade_in <= 4'd9);
  assign w_dwell_last = (r_dwell == DW'(DWELL - 1));
  assign w_store      = ~bus.clear & w_load_rise & w_grade_ok & ~w_full;

  // State register
  always_ff @(posedge clk_2) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; clear and run=0 both abort to IDLE
  always_comb begin
    w_state_next = r_state;
    if (bus.clear) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:        if (bus.run && r_count != '0) w_state_next = SHOW_GRADE;
        SHOW_GRADE:  if (!bus.run) w_state_next = IDLE;
                     else if (w_dwell_last) w_state_next = SHOW_STATUS;
        SHOW_STATUS: if (!bus.run) w_state_next = IDLE;
                     else if (w_dwell_last) w_state_next = SHOW_GRADE;
        default:     w_state_next = IDLE;
      endcase
    end
  end

  // Output logic computed against the next state so the registered outputs
  // line up with the state they describe.
  always_comb begin
    w_dwell_next = '0;
    w_slot_next  = r_slot;
    if (w_state_next == IDLE) begin
      w_slot_next = '0;
    end else if (r_state != IDLE) begin
      w_dwell_next = w_dwell_last ? '0 : r_dwell + DW'(1);
      if (r_state == SHOW_STATUS && w_dwell_last)
        w_slot_next = ((CW'(r_slot) + CW'(1)) == r_count) ? '0 : r_slot + SW'(1);
    end
    w_nota_next = (w_state_next == IDLE) ? bus.grade_in : r_mem[w_slot_next];
    w_show_next = (w_state_next == SHOW_STATUS);
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_count     <= '0;
      r_slot      <= '0;
      r_dwell     <= '0;
      r_err       <= 1'b0;
      r_nota      <= '0;
      r_show      <= 1'b0;
      r_load_prev <= 1'b1;
    end else begin
      r_load_prev <= bus.load;
      r_slot      <= w_slot_next;
      r_dwell     <= w_dwell_next;
      r_nota      <= w_nota_next;
      r_show      <= w_show_next;
      if (bus.clear) begin
        r_count <= '0;
        r_err   <= 1'b0;
      end else if (w_load_rise) begin
        if (w_store) begin
          r_count <= r_count + CW'(1);
          r_err   <= 1'b0;
        end else begin
          r_err   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (!reset && w_store) r_mem[r_count[SW-1:0]] <= bus.grade_in;
  end

  assign bus.nota_out    = r_nota;
  assign bus.show_status = r_show;
  assign bus.slot_out    = r_slot;
  assign bus.count_out   = r_count;
  assign bus.full        = w_full;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_grade_display_sequencer.sv
// Scoreboard bench for grade_display_sequencer with NSLOTS=8, DWELL=2.
module tb_grade_display_sequencer;
  localparam int unsigned NSLOTS = 8;
  localparam int unsigned DWELL  = 2;

  logic clk_2 = 1'b0;
  logic reset;

  grade_display_sequencer_if #(.NSLOTS(NSLOTS)) bus ();

  grade_display_sequencer #(.NSLOTS(NSLOTS), .DWELL(DWELL)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic expect_count_err(input string tag, input int cnt, input int er);
    push({tag, "_count"}, cnt);
    push({tag, "_err"}, er);
    pop_check(int'(bus.count_out));
    pop_check(int'(bus.err));
  endtask

  // One clock of display; expected triple queued before the edge.
  task automatic step(input string tag, input int nota, input int show, input int slot);
    push({tag, "_nota"}, nota);
    push({tag, "_show"}, show);
    push({tag, "_slot"}, slot);
    tick();
    pop_check(int'(bus.nota_out));
    pop_check(int'(bus.show_status));
    pop_check(int'(bus.slot_out));
  endtask

  task automatic do_load(input int g);
    bus.grade_in = 4'(g);
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seq_n [13] = '{2,2,2,2,5,5,5,5,8,8,8,8,2};
    int seq_s [13] = '{0,0,1,1,0,0,1,1,0,0,1,1,0};
    int seq_l [13] = '{0,0,0,0,1,1,1,1,2,2,2,2,0};

    reset        = 1'b1;
    bus.load     = 1'b1;
    bus.grade_in = 4'd5;
    bus.clear    = 1'b0;
    bus.run      = 1'b0;
    repeat (3) tick();

    expect_count_err("reset", 0, 0);
    push("reset_nota", 0);
    push("reset_show", 0);
    push("reset_slot", 0);
    push("reset_full", 0);
    pop_check(int'(bus.nota_out));
    pop_check(int'(bus.show_status));
    pop_check(int'(bus.slot_out));
    pop_check(int'(bus.full));

    // load held high across reset release must not store
    reset = 1'b0;
    tick();
    tick();
    expect_count_err("held_load", 0, 0);
    push("idle_nota", 5);
    pop_check(int'(bus.nota_out));
    bus.load = 1'b0;
    tick();
    bus.load = 1'b1;
    tick();
    expect_count_err("first_rise", 1, 0);
    bus.load = 1'b0;
    tick();

    bus.grade_in = 4'd12;
    bus.load = 1'b1;
    tick();
    expect_count_err("bad_grade", 1, 1);
    bus.load = 1'b0;
    tick();
    do_load(4);
    expect_count_err("good_after_bad", 2, 0);

    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    expect_count_err("clear", 0, 0);

    do_load(2);
    do_load(5);
    do_load(8);
    expect_count_err("three", 3, 0);

    bus.run = 1'b1;
    for (int i = 0; i < 13; i++) step("rot", seq_n[i], seq_s[i], seq_l[i]);
    step("rot2", 2, 0, 0);
    step("rot2", 2, 1, 0);
    step("rot2", 2, 1, 0);
    step("rot2", 5, 0, 1);
    step("rot2", 5, 0, 1);
    step("rot2", 5, 1, 1);

    // clear beats load while running in SHOW_STATUS at slot 1
    bus.clear    = 1'b1;
    bus.load     = 1'b1;
    bus.grade_in = 4'd3;
    bus.run      = 1'b0;
    step("clr_run", 3, 0, 0);
    expect_count_err("clr_run", 0, 0);
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    tick();
    expect_count_err("clr_nostore", 0, 0);

    for (int k = 1; k <= 9; k++) begin
      do_load(k - 1);
      push("fill_count", (k > 8) ? 8 : k);
      push("fill_full", (k >= 8) ? 1 : 0);
      push("fill_err", (k > 8) ? 1 : 0);
      pop_check(int'(bus.count_out));
      pop_check(int'(bus.full));
      pop_check(int'(bus.err));
    end

    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    do_load(1);
    do_load(3);
    expect_count_err("two", 2, 0);
    bus.run = 1'b1;
    step("join", 1, 0, 0);
    step("join", 1, 0, 0);
    step("join", 1, 1, 0);
    step("join", 1, 1, 0);
    step("join", 3, 0, 1);
    bus.grade_in = 4'd7;
    bus.load     = 1'b1;
    step("join", 3, 0, 1);
    expect_count_err("join_load", 3, 0);
    bus.load = 1'b0;
    step("join", 3, 1, 1);
    step("join", 3, 1, 1);
    step("join", 7, 0, 2);
    step("join", 7, 0, 2);
    step("join", 7, 1, 2);
    step("join", 7, 1, 2);
    step("join", 1, 0, 0);
    bus.run = 1'b0;
    step("stop", 7, 0, 0);
    step("stop_idle", 7, 0, 0);
    expect_count_err("stop", 3, 0);

    if (sb.size() != 0) check("sb_leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
